// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: one-hot registered grant, locked for whole packets,
// holder keeps the grant for up to wt[i] packets before priority rotates.
module wrr_arb #(
    parameter int N  = 4,
    parameter int WW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          ack,
    input  logic          last,
    input  logic          wt_wr,
    input  logic [IW-1:0] wt_idx,
    input  logic [WW-1:0] wt_data,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [IW:0] N_L = (IW+1)'(N);

    state_t        state_reg, state_next;
    logic [N-1:0]  gnt_reg, gnt_next;
    logic [IW-1:0] gnt_id_reg, gnt_id_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [WW-1:0] cred_reg, cred_next;
    logic          busy_reg;
    logic [WW-1:0] wt_reg [N];

    logic [IW-1:0] gnt_id_inc;
    logic [IW-1:0] base;
    logic [IW:0]   sum_w;
    logic [IW-1:0] win_id;
    logic          win_vld;

    // Weight entries; a write index matching no entry is simply dropped.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_wt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wt_reg[gi] <= WW'(1);
                end else if (wt_wr && (wt_idx == IW'(gi))) begin
                    wt_reg[gi] <= (wt_data == '0) ? WW'(1) : wt_data;
                end
            end
        end
    endgenerate

    assign gnt_id_inc = (gnt_id_reg == IW'(N-1)) ? '0 : gnt_id_reg + IW'(1);

    // In GRANT the arbiter is only consulted at allocation end, where the
    // pointer has just moved past the holder.
    assign base = (state_reg == GRANT) ? gnt_id_inc : ptr_reg;

    // Scan downward in offset so the lowest offset from base wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        sum_w   = '0;
        for (int k = N-1; k >= 0; k--) begin
            sum_w = {1'b0, base} + (IW+1)'(k);
            if (sum_w >= N_L) begin
                sum_w = sum_w - N_L;
            end
            if (req[sum_w[IW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = sum_w[IW-1:0];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        gnt_id_next = gnt_id_reg;
        ptr_next    = ptr_reg;
        cred_next   = cred_reg;
        case (state_reg)
            IDLE: begin
                if (win_vld) begin
                    state_next  = GRANT;
                    gnt_next    = {{(N-1){1'b0}}, 1'b1} << win_id;
                    gnt_id_next = win_id;
                    cred_next   = wt_reg[win_id];
                end
            end
            GRANT: begin
                if (ack && last) begin
                    if ((cred_reg > WW'(1)) && req[gnt_id_reg]) begin
                        cred_next = cred_reg - WW'(1);
                    end else begin
                        ptr_next = gnt_id_inc;
                        if (win_vld) begin
                            gnt_next    = {{(N-1){1'b0}}, 1'b1} << win_id;
                            gnt_id_next = win_id;
                            cred_next   = wt_reg[win_id];
                        end else begin
                            state_next  = IDLE;
                            gnt_next    = '0;
                            gnt_id_next = '0;
                        end
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                gnt_next    = '0;
                gnt_id_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            gnt_reg    <= '0;
            gnt_id_reg <= '0;
            ptr_reg    <= '0;
            cred_reg   <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            gnt_id_reg <= gnt_id_next;
            ptr_reg    <= ptr_next;
            cred_reg   <= cred_next;
            busy_reg   <= |gnt_next;
        end
    end

    assign gnt    = gnt_reg;
    assign gnt_id = gnt_id_reg;
    assign busy   = busy_reg;

endmodule

// File: doc/wrr_arb.md
# wrr_arb

Weighted round-robin arbiter with packet-level grant locking. It shares one downstream resource between `N` requesters. A winner holds the grant for up to `weight[i]` complete packets before priority rotates to the next requester. It is the grant controller in front of shared datapaths: it takes a plain one-hot `req` vector and emits a registered one-hot grant that stays stable across multi-beat transfers.

## Interface
- `N`, 4, number of requesters (≥2)
- `WW`, 4, weight/credit width in bits; weight range 1..2^WW-1
- `clk`  input  1  clock; all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `req`  input  N  per-requester request, level-sensitive
- `ack`  input  1  downstream accepted one beat from the granted requester
- `last`  input  1  qualifies `ack`: beat is final beat of a packet
- `wt_wr`  input  1  weight-table write strobe
- `wt_idx`  input  $clog2(N)  weight-table write index
- `wt_data`  input  WW  weight value written
- `gnt`  output  N  registered one-hot grant; all-zero when idle
- `gnt_id`  output  $clog2(N)  binary index of `gnt`; 0 when idle
- `busy`  output  1  `gnt` non-zero

## Operation
- **State.** FSM with two states, IDLE and GRANT. Supporting registers:
  - rotating priority pointer `ptr`
  - per-requester weight table `wt[N]`
  - credit counter `cred` (WW bits)
- **Reset.** Reset asserted (async) gives:
  - state IDLE, `gnt`=0, `gnt_id`=0, `busy`=0
  - `ptr`=0, `cred`=0, all `wt[i]`=1
- **Arbitration function.**
  - Choose the first set bit of `req` scanning from `ptr` upward, wrapping modulo N.
  - `ptr` itself has highest priority.
- **IDLE.**
  - If `req`≠0: register the winner into `gnt`, load `cred`=`wt[winner]`, go to GRANT.
  - Otherwise stay.
- **GRANT, no `ack`.** Hold `gnt`.
- **GRANT, `ack`&!`last`.** Mid-packet beat; `gnt` and `cred` are unchanged.
- **GRANT, `ack`&`last`, allocation continues.** Applies when `cred`>1 and `req[gnt_id]`=1:
  - `cred`--, `gnt` held.
- **GRANT, `ack`&`last`, allocation ends.** Applies when `cred`≤1 or `req[gnt_id]`=0:
  - `ptr` ← (`gnt_id`+1) mod N.
  - Re-arbitrate in the same cycle using the new `ptr` against the current `req`.
  - If there is a winner: register the new `gnt`, reload `cred`, stay in GRANT (zero-bubble handover).
  - If there is no winner: `gnt`←0, go to IDLE.
- **Sole requester.** A sole requester with exhausted credit re-wins. `gnt` stays continuously asserted and `cred` reloads.
- **`req` dropped mid-packet by holder.** This is a protocol violation. The grant is still held until `ack`&`last`; the lock is never broken early.
- **`ack` ignored.** `ack` in IDLE is ignored.
- **Weight writes.**
  - `wt_wr` writes `wt[wt_idx]`←`wt_data`.
  - `wt_data`=0 is stored as 1.
  - `wt_idx`≥N is ignored.
  - A write affects only the next credit load; the current `cred` is untouched.
  - When a write and a load of the same entry occur in the same cycle, the load uses the old value.

## Timing
- Request to grant latency: 1 cycle. `req` sampled at edge k gives `gnt` valid after edge k.
- Handover latency: `ack`&`last` at edge k gives the new `gnt` after edge k. No idle cycle appears between grants.
- `gnt`, `gnt_id` and `busy` are flop outputs with no combinational path from inputs.
- `gnt` is always one-hot or zero.
- Credit arithmetic is unsigned WW-bit and never wraps: it is decremented only when >1 and reloaded with ≥1.
- Async reset mid-packet clears `gnt` immediately, without waiting for a clock. The first grant after `rst_n` deasserts follows the IDLE rule.

## Test plan
- **Reset values.** Reset with `req`=4'b1111 held → `gnt`=0, `busy`=0 while `rst_n`=0. The first edge after release gives `gnt`=4'b0001.
- **Equal weights.** All weights 1, `req`=4'b1111, `ack`&`last` every cycle → `gnt` sequence 0001, 0010, 0100, 1000, 0001, with no bubbles.
- **Weighted rotation.**
  - Setup: `wt[0]`=3, others 1, all requesting, single-beat packets.
  - Expected `gnt_id` sequence: 0, 0, 0, 1, 2, 3, 0, 0, 0.
- **Multi-beat lock.**
  - Setup: requester 2 granted; `ack` for 3 beats with `last` on the 3rd; requester 1 also requesting.
  - Expected: `gnt`=0100 through all 3 beats, then 1000 if requester 3 is requesting, else 0010.
- **Early release and sole requester.**
  - Early release: `wt[1]`=4, requester 1 drops `req` before its 2nd packet's `last` → handover right after that `last`.
  - Sole requester: `req`=0001, `wt[0]`=2, continuous `ack`&`last` → `gnt` stays 0001 indefinitely.
- **Mid-operation events.**
  - Weight write during GRANT to the holder's entry → current credit unchanged; the new weight applies at the next win.
  - `rst_n` pulsed low mid-packet → `gnt`=0 asynchronously, and `wt` returns to 1.
